// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles 16-bit words into instruction memory from address 0,
// verifies an XOR checksum, and releases the CPU reset only after a good image.
module prog_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst_b,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_b_q, cpu_rst_b_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [7:0]          data_hi_q, data_hi_d;
  logic [7:0]          csum_q, csum_d;

  logic                xfer;
  logic [16:0]         n_full;
  logic [ADDR_W:0]     wl_inc;

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_rst_b_d    = cpu_rst_b_q;
    done_d         = done_q;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;
    len_hi_d       = len_hi_q;
    len_d          = len_q;
    data_hi_d      = data_hi_q;
    csum_d         = csum_q;

    xfer   = in_valid & in_ready_q;
    n_full = {1'b0, len_hi_q, in_data};
    wl_inc = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (xfer && in_data == 8'hA5) begin
          state_d        = S_LEN_HI;
          words_loaded_d = '0;
          csum_d         = '0;
          done_d         = 1'b0;
          error_d        = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = n_full[ADDR_W:0];
          if (n_full > CAP) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            in_ready_d = 1'b0;
          end else if (n_full == 17'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          data_hi_d = in_data;
          csum_d    = csum_q ^ in_data;
          state_d   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          csum_d         = csum_q ^ in_data;
          mem_we_d       = 1'b1;
          mem_addr_d     = words_loaded_q[ADDR_W-1:0];
          mem_wdata_d    = {data_hi_q, in_data};
          words_loaded_d = wl_inc;
          state_d        = (wl_inc == len_q) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          in_ready_d = 1'b0;
          if (in_data == csum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_rst_b_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        // done/error stay visible until the next header byte starts a new frame
        if (start) begin
          state_d     = S_IDLE;
          cpu_rst_b_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b1;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_rst_b_q    <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_rst_b_q    <= cpu_rst_b_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  // Datapath holding registers are always initialised on the path that uses them.
  always_ff @(posedge clk) begin
    len_hi_q  <= len_hi_d;
    len_q     <= len_d;
    data_hi_q <= data_hi_d;
    csum_q    <= csum_d;
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rst_b    = cpu_rst_b_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that sits between a host byte link and the CPU instruction memory. It receives a framed image, assembles 16-bit words, writes them to consecutive memory addresses from 0, and verifies a checksum. It holds the CPU in reset (`cpu_rst_b` low) until an image has loaded successfully, replacing static preloading of a `.mem` file at elaboration.

## Interface
- `ADDR_W`, 9: instruction memory address width; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR; ignored in other states.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  8  offered byte.
- `in_ready`  out  1  loader can accept a byte; a transfer happens on a cycle with `in_valid & in_ready`.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  16  write data.
- `cpu_rst_b`  out  1  active-low CPU reset; high only in DONE.
- `done`  out  1  image loaded and checksum correct.
- `error`  out  1  frame rejected.
- `words_loaded`  out  ADDR_W+1  count of words written for the current frame.

## Operation
- Frame format: header byte 0xA5, length high byte, length low byte, then N words each sent high byte first, then a 1-byte checksum.
  - N is the 16-bit word count.
  - Checksum is the XOR of all data bytes only; the header and length bytes are not included.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE:
  - Byte 0xA5 moves to LEN_HI.
  - Any other byte is discarded and the FSM stays in IDLE.
  - On entering LEN_HI: clear the word counter, the checksum accumulator, `words_loaded`, `done` and `error`.
- LEN_HI: latch the high length byte, then go to LEN_LO.
- LEN_LO, with N the completed length:
  - N > 2^ADDR_W goes to ERROR.
  - N = 0 goes to CHECK.
  - Otherwise go to DATA_HI.
- DATA_HI: latch the byte into bits [15:8], XOR it into the checksum, go to DATA_LO.
- DATA_LO:
  - Form the word and XOR the byte into the checksum.
  - Write: `mem_wdata` = word, `mem_addr` = word index, `mem_we` = 1.
  - Increment the index and `words_loaded`.
  - If the index has reached N, go to CHECK; otherwise go to DATA_HI.
- CHECK:
  - Received byte equal to the accumulated checksum goes to DONE.
  - Otherwise go to ERROR. Words already written stay in memory.
- DONE: `done` = 1, `cpu_rst_b` = 1, `in_ready` = 0.
- ERROR: `error` = 1, `cpu_rst_b` = 0, `in_ready` = 0.
- A `start` pulse in DONE or ERROR returns to IDLE and drives `cpu_rst_b` low on the next cycle.
- `in_ready` is 1 in IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- All outputs are registered.

## Timing
- Values after reset:
  - FSM in IDLE.
  - `in_ready` = 1.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_rst_b` = 0, `done` = 0, `error` = 0, `words_loaded` = 0.
- Write latency: `mem_we` is high for exactly the one cycle after the DATA_LO transfer. `mem_addr`/`mem_wdata` are valid in that same cycle.
- Back-to-back bytes, one per cycle, are accepted with no bubbles. If `in_valid` = 0, the FSM holds its state.
- Status latency:
  - `done` and `cpu_rst_b` rise the cycle after the checksum transfer.
  - `error` rises the cycle after the offending transfer (LEN_LO overflow or bad checksum).
- Exact capacity: N = 2^ADDR_W is accepted, and the last write goes to address 2^ADDR_W−1. `words_loaded` is 1 bit wider than the address so it can hold 2^ADDR_W without wrapping.
- `rst` asserted mid-frame:
  - Next cycle: IDLE with all outputs at their reset values, including `mem_we` = 0.
  - Memory contents are not touched.
- `start` together with `rst`: `rst` wins.
- `start` together with a valid byte while in DONE: the byte is not accepted, because `in_ready` = 0 in DONE.

## Test plan
- Normal load, `ADDR_W` = 9. Stream A5 00 03 12 34 AB CD 00 01 41.
  - Three `mem_we` pulses: addr 0 ← 0x1234, addr 1 ← 0xABCD, addr 2 ← 0x0001.
  - Then `done` = 1, `cpu_rst_b` = 1, `words_loaded` = 3, `in_ready` = 0.
- Bad checksum: the same stream ending in 42 instead of 41.
  - Three writes occur, then `error` = 1 and `cpu_rst_b` stays 0.
  - A `start` pulse returns the loader to IDLE with `in_ready` = 1.
- Garbage and empty image: stream 00 FF 5A A5 00 00 00.
  - The first three bytes are ignored and no writes occur.
  - `done` = 1 and `words_loaded` = 0.
- Capacity, `ADDR_W` = 4:
  - A5 00 11 gives `error` the cycle after the third byte.
  - A5 00 10 followed by 16 words loads addresses 0–15, and `words_loaded` = 16.
- Reset mid-frame: after A5 00 05 and two words, assert `rst` for one cycle.
  - All outputs return to their reset values.
  - A following correct frame loads from address 0.
- Backpressure: hold `in_valid` = 1 with random gaps between bytes. Each byte is accepted exactly once, and the result is identical to the back-to-back case.
